// File: rtl/clk40_sync_supervisor_if.sv
// rtl/clk40_sync_supervisor_if.sv - control/status bundle between the sync supervisor and its user
interface clk40_sync_supervisor_if #(
    parameter int ERR_W = 8
);
    logic             enable;
    logic             sync_in;
    logic             clr_err;
    logic             decoder_en;
    logic             locked;
    logic             strobe40;
    logic [2:0]       phase;
    logic             sync_err;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state;

    modport master (
        output enable, sync_in, clr_err,
        input  decoder_en, locked, strobe40, phase, sync_err, err_cnt, state
    );

    modport slave (
        input  enable, sync_in, clr_err,
        output decoder_en, locked, strobe40, phase, sync_err, err_cnt, state
    );
endinterface

// File: rtl/clk40_sync_supervisor.sv
// rtl/clk40_sync_supervisor.sv - 40 MHz sync pulse lock supervisor in the 320 MHz domain
module clk40_sync_supervisor #(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 2,
    parameter int ERR_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    clk40_sync_supervisor_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10,
        LOST   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       fr_q;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       good_q, good_d;
    logic [2:0]       miss_q, miss_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             locked_q, sync_err_q, strobe_q, strobe_d;
    logic             on_time, early, missing, to_lost;

    assign on_time = bus.sync_in && (cnt_q == 3'd7);
    assign early   = bus.sync_in && (cnt_q != 3'd7);
    assign missing = !bus.sync_in && (cnt_q == 3'd7);
    assign cnt_d   = bus.sync_in ? 3'd0 : cnt_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        miss_d   = miss_q;
        phase_d  = phase_q;
        strobe_d = 1'b0;
        to_lost  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            good_d  = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQ;
                    good_d  = '0;
                    miss_d  = '0;
                end
                ACQ: begin
                    // Any pulse that is not an on-time continuation restarts the run at 1.
                    if (bus.sync_in)
                        good_d = (on_time && good_q != 4'd0) ? good_q + 4'd1 : 4'd1;
                    else if (missing)
                        good_d = '0;
                    if (good_d == LOCK_COUNT[3:0]) begin
                        state_d = LOCKED;
                        phase_d = fr_q;
                        miss_d  = '0;
                    end
                end
                LOCKED: begin
                    if (early) begin
                        to_lost = 1'b1;
                    end else if (on_time) begin
                        miss_d = '0;
                    end else if (missing) begin
                        miss_d = miss_q + 3'd1;
                        if (miss_d == MISS_LIMIT[2:0])
                            to_lost = 1'b1;
                    end
                    if (to_lost)
                        state_d = LOST;
                    else
                        strobe_d = on_time || missing;
                end
                LOST: begin
                    state_d = ACQ;
                    good_d  = bus.sync_in ? 4'd1 : 4'd0;
                    miss_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (bus.clr_err)
            err_d = '0;
        else if (to_lost && err_q != '1)
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fr_q       <= '0;
            phase_q    <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            err_q      <= '0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b1;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fr_q       <= fr_q + 3'd1;
            phase_q    <= phase_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            locked_q   <= (state_q == LOCKED);
            sync_err_q <= (state_q != LOCKED);
            strobe_q   <= strobe_d;
        end
    end

    assign bus.decoder_en = locked_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.strobe40   = strobe_q;
    assign bus.phase      = phase_q;
    assign bus.err_cnt    = err_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_clk40_sync_supervisor.sv
// tb/tb_clk40_sync_supervisor.sv - scoreboard bench for clk40_sync_supervisor
module tb_clk40_sync_supervisor;
    localparam int ERR_W = 2;

    localparam int S_STATE  = 0;
    localparam int S_LOCKED = 1;
    localparam int S_DEC    = 2;
    localparam int S_SERR   = 3;
    localparam int S_STB    = 4;
    localparam int S_ERR    = 5;
    localparam int S_PHASE  = 6;

    typedef struct {
        int cyc;
        int sel;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    clk40_sync_supervisor_if #(.ERR_W(ERR_W)) bus ();

    clk40_sync_supervisor #(
        .LOCK_COUNT (4),
        .MISS_LIMIT (2),
        .ERR_W      (ERR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int sel);
        case (sel)
            S_STATE:  return int'(bus.state);
            S_LOCKED: return int'(bus.locked);
            S_DEC:    return int'(bus.decoder_en);
            S_SERR:   return int'(bus.sync_err);
            S_STB:    return int'(bus.strobe40);
            S_ERR:    return int'(bus.err_cnt);
            default:  return int'(bus.phase);
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            S_STATE:  return "state";
            S_LOCKED: return "locked";
            S_DEC:    return "decoder_en";
            S_SERR:   return "sync_err";
            S_STB:    return "strobe40";
            S_ERR:    return "err_cnt";
            default:  return "phase";
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s stale entry for cycle %0d at cycle %0d", sname(e.sel), e.cyc, cyc);
            end else if (actual(e.sel) != e.val) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %0d expected %0d", sname(e.sel), cyc, actual(e.sel), e.val);
            end
        end
    end

    task automatic expect_now(input int sel, input int val);
        exp_t e;
        e.cyc = cyc;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_reset();
        expect_now(S_STATE, 0);
        expect_now(S_LOCKED, 0);
        expect_now(S_DEC, 0);
        expect_now(S_SERR, 1);
        expect_now(S_STB, 0);
        expect_now(S_ERR, 0);
        expect_now(S_PHASE, 0);
    endtask

    task automatic run(input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            bus.sync_in = s;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lose_once(input logic clr, input int exp_err);
        run(1, 1'b1);
        repeat (3) begin
            run(7, 1'b0);
            run(1, 1'b1);
        end
        expect_now(S_STATE, 2);
        run(3, 1'b0);
        bus.clr_err = clr;
        run(1, 1'b1);
        bus.clr_err = 1'b0;
        expect_now(S_STATE, 3);
        expect_now(S_ERR, exp_err);
        run(1, 1'b0);
        expect_now(S_STATE, 1);
    endtask

    initial begin
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.sync_in = 1'b0;
        bus.clr_err = 1'b0;
        run(3, 1'b0);
        expect_reset();

        reset = 1'b0;
        run(3, 1'b0);
        bus.enable = 1'b1;
        run(1, 1'b1);
        expect_now(S_STATE, 1);
        for (int p = 0; p < 4; p++) begin
            run(7, 1'b0);
            run(1, 1'b1);
        end
        expect_now(S_STATE, 2);
        expect_now(S_LOCKED, 0);
        expect_now(S_PHASE, 3);
        run(1, 1'b0);
        expect_now(S_LOCKED, 1);
        expect_now(S_DEC, 1);
        expect_now(S_SERR, 0);
        expect_now(S_STB, 0);
        run(6, 1'b0);
        run(1, 1'b1);
        expect_now(S_STB, 1);
        run(1, 1'b0);
        expect_now(S_STB, 0);

        run(6, 1'b0);
        run(1, 1'b0);
        expect_now(S_STATE, 2);
        expect_now(S_STB, 1);
        run(7, 1'b0);
        run(1, 1'b0);
        expect_now(S_STATE, 3);
        expect_now(S_STB, 0);
        expect_now(S_ERR, 1);
        run(1, 1'b0);
        expect_now(S_STATE, 1);
        expect_now(S_LOCKED, 0);
        expect_now(S_SERR, 1);

        run(6, 1'b0);
        run(1, 1'b1);
        for (int p = 0; p < 4; p++) begin
            run(7, 1'b0);
            run(1, 1'b1);
        end
        expect_now(S_LOCKED, 1);
        expect_now(S_STB, 1);
        expect_now(S_ERR, 1);

        run(4, 1'b0);
        run(1, 1'b1);
        expect_now(S_STATE, 3);
        expect_now(S_ERR, 2);
        expect_now(S_STB, 0);
        run(1, 1'b0);
        expect_now(S_STATE, 1);
        expect_now(S_DEC, 0);

        lose_once(1'b0, 3);
        lose_once(1'b0, 3);
        lose_once(1'b0, 3);
        lose_once(1'b1, 0);
        lose_once(1'b0, 1);

        run(1, 1'b1);
        repeat (3) begin
            run(7, 1'b0);
            run(1, 1'b1);
        end
        expect_now(S_STATE, 2);
        run(1, 1'b0);
        expect_now(S_LOCKED, 1);
        bus.enable = 1'b0;
        run(1, 1'b0);
        expect_now(S_STATE, 0);
        expect_now(S_ERR, 1);
        run(1, 1'b0);
        expect_now(S_LOCKED, 0);
        expect_now(S_DEC, 0);
        expect_now(S_SERR, 1);
        expect_now(S_ERR, 1);

        bus.enable = 1'b1;
        run(1, 1'b0);
        expect_now(S_STATE, 1);
        run(1, 1'b1);
        reset = 1'b1;
        run(1, 1'b0);
        expect_reset();
        reset = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
